// File: rtl/ppu_attr_pkg.sv
// Shared constants and FSM state encoding for the nametable attribute writer.
// ST_VFY exists only when ATTR_WRITER_READBACK_EN is defined.
package ppu_attr_pkg;

   localparam logic [15:0] ATTR_TABLE_OFS = 16'h03C0;
   localparam logic [15:0] NT_BASE_MASK   = 16'hFC00;
   localparam logic [15:0] NT_OFS_MASK    = 16'h03FF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
`ifdef ATTR_WRITER_READBACK_EN
      ST_VFY  = 3'd3,
`endif
      ST_FIN  = 3'd4
   } state_e;

endpackage

// File: rtl/attr_writer_if.sv
// Request, status and VRAM access signals of attr_writer; slave = the writer, master = its environment.
interface attr_writer_if;

   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_nt_addr;
   logic [1:0]  req_pal;
   logic        busy;
   logic        done;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport master (
      output req_valid, req_nt_addr, req_pal, mem_rdata, mem_ack,
      input  req_ready, busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_nt_addr, req_pal, mem_rdata, mem_ack,
      output req_ready, busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/attr_addr_calc.sv
// Combinational map from a nametable tile address to its attribute byte address,
// 2-bit quadrant index and an "address already inside the attribute table" flag.
module attr_addr_calc
   import ppu_attr_pkg::*;
(
   input  logic [15:0] nt_addr_i,
   output logic [15:0] attr_addr_o,
   output logic [1:0]  quad_o,
   output logic        oob_o
);

   logic [15:0] base;
   logic [15:0] off;
   logic [4:0]  row;
   logic [4:0]  col;

   assign base = nt_addr_i & NT_BASE_MASK;
   assign off  = nt_addr_i & NT_OFS_MASK;
   assign row  = off[9:5];
   assign col  = off[4:0];

   // Max offset is 0x3C0 + 7*8 + 7 = 0x3FF, so the sum never carries into base.
   assign attr_addr_o = base + ATTR_TABLE_OFS + {10'd0, row[4:2], 3'd0} + {13'd0, col[4:2]};
   assign quad_o      = {row[1], col[1]};
   assign oob_o       = (off >= ATTR_TABLE_OFS);

endmodule

// File: rtl/attr_writer.sv
// Read-modify-write of one 2-bit palette field in a VRAM attribute byte; done 3 cycles after transfer
// with zero-wait acks, one request at a time (req_ready only in IDLE). ATTR_WRITER_READBACK_EN adds a verify read.
module attr_writer
   import ppu_attr_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   attr_writer_if.slave bus
);

   localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   addr_q, addr_d;
   logic [1:0]    quad_q, quad_d;
   logic [1:0]    pal_q, pal_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          err_q, err_d;

   logic [15:0]   calc_addr;
   logic [1:0]    calc_quad;
   logic          calc_oob;
   logic [7:0]    pal_mask;
   logic [7:0]    merged;
   logic          timed_out;

   attr_addr_calc u_calc (
      .nt_addr_i   (bus.req_nt_addr),
      .attr_addr_o (calc_addr),
      .quad_o      (calc_quad),
      .oob_o       (calc_oob)
   );

   assign pal_mask  = 8'h03 << {quad_q, 1'b0};
   assign merged    = (bus.mem_rdata & ~pal_mask) | ({6'd0, pal_q} << {quad_q, 1'b0});
   assign timed_out = (cnt_q == CNT_LAST);

   // Counter defaults to zero so every state change restarts the wait count.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      addr_d  = addr_q;
      quad_d  = quad_q;
      pal_d   = pal_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = calc_addr;
               quad_d  = calc_quad;
               pal_d   = bus.req_pal;
               err_d   = calc_oob;
               state_d = calc_oob ? ST_FIN : ST_RD;
            end
         end
         ST_RD: begin
            if (bus.mem_ack) begin
               wdata_d = merged;
               state_d = ST_WR;
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WR: begin
            if (bus.mem_ack) begin
`ifdef ATTR_WRITER_READBACK_EN
               state_d = ST_VFY;
`else
               state_d = ST_FIN;
`endif
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef ATTR_WRITER_READBACK_EN
         ST_VFY: begin
            if (bus.mem_ack) begin
               err_d   = (bus.mem_rdata != wdata_q);
               state_d = ST_FIN;
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         quad_q  <= '0;
         pal_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         quad_q  <= quad_d;
         pal_q   <= pal_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_FIN);
   assign bus.err       = (state_q == ST_FIN) && err_q;
`ifdef ATTR_WRITER_READBACK_EN
   assign bus.mem_req   = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_VFY);
`else
   assign bus.mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
`endif
   assign bus.mem_we    = (state_q == ST_WR);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_attr_writer.sv
// Scoreboard bench for attr_writer: directed requests push expected VRAM accesses and completions,
// a negedge monitor pops and compares them (including cycle stamps) as the DUT presents them.
module tb_attr_writer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   attr_writer_if bus ();

   attr_writer #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          kind;   // 0 = memory access, 1 = done pulse
      bit          we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      bit          err;
      int          stamp;  // edge number at which the ack / done is sampled
      bit          noack;
   } exp_t;

   exp_t sb[$];
   int   cyc  = 0;
   int   nchk = 0;
   int   nerr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Memory model: ack after ack_wait idle cycles of each access; knobs suppress or fake acks.
   int         ack_wait  = 0;
   bit         no_ack    = 0;
   bit         no_ack_wr = 0;
   bit         spurious  = 0;
   logic [7:0] rd_data   = 8'h00;
   int         wcnt      = 0;

   initial begin
      bus.req_valid   = 1'b0;
      bus.req_nt_addr = 16'h0000;
      bus.req_pal     = 2'd0;
      bus.mem_rdata   = 8'h00;
      bus.mem_ack     = 1'b0;
   end

   always @(posedge clk) begin
      #1;
      if (bus.mem_ack || !bus.mem_req) wcnt = 0;
      bus.mem_rdata = rd_data;
      if (spurious)
         bus.mem_ack = 1'b1;
      else if (bus.mem_req && !no_ack && !(no_ack_wr && bus.mem_we) && wcnt == ack_wait)
         bus.mem_ack = 1'b1;
      else begin
         bus.mem_ack = 1'b0;
         if (bus.mem_req) wcnt++;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_req) begin
            if (sb.size() == 0 || sb[0].kind != 1'b0)
               chk("unexpected_mem_req", {16'h0, bus.mem_addr}, 32'hFFFF_FFFF);
            else begin
               chk("mem_we", bus.mem_we, sb[0].we);
               chk("mem_addr", bus.mem_addr, sb[0].addr);
               if (sb[0].we) chk("mem_wdata", bus.mem_wdata, sb[0].wdata);
               if (bus.mem_ack) begin
                  chk("access_cycle", cyc + 1, sb[0].stamp);
                  void'(sb.pop_front());
               end
            end
         end
         if (bus.done) begin
            while (sb.size() > 0 && sb[0].kind == 1'b0 && sb[0].noack) void'(sb.pop_front());
            if (sb.size() == 0 || sb[0].kind != 1'b1)
               chk("unexpected_done", bus.done, 1'b0);
            else begin
               chk("done_err", bus.err, sb[0].err);
               chk("done_cycle", cyc + 1, sb[0].stamp);
               void'(sb.pop_front());
            end
         end
         if (bus.err && !bus.done) chk("err_without_done", bus.err, 1'b0);
      end
   end

   function automatic void push_acc(input bit we, input logic [15:0] a, input logic [7:0] d,
                                    input int stamp, input bit noack);
      exp_t e;
      e.kind = 1'b0; e.we = we; e.addr = a; e.wdata = d; e.err = 1'b0; e.stamp = stamp; e.noack = noack;
      sb.push_back(e);
   endfunction

   function automatic void push_done(input bit err, input int stamp);
      exp_t e;
      e.kind = 1'b1; e.we = 1'b0; e.addr = 16'h0; e.wdata = 8'h0; e.err = err; e.stamp = stamp; e.noack = 1'b0;
      sb.push_back(e);
   endfunction

   // Full read-write(-verify) path with w wait cycles per access; rd is what every read returns.
   function automatic void exp_rw(input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rd,
                                  input int t, input int w);
      push_acc(1'b0, a, 8'h00, t + 1 + w, 1'b0);
      push_acc(1'b1, a, wd, t + 2 + 2 * w, 1'b0);
`ifdef ATTR_WRITER_READBACK_EN
      push_acc(1'b0, a, 8'h00, t + 3 + 3 * w, 1'b0);
      push_done(rd != wd, t + 4 + 3 * w);
`else
      push_done(1'b0, t + 3 + 2 * w);
`endif
   endfunction

   // Drives a request at a negedge; t is the edge that transfers it.
   task automatic issue(input logic [15:0] a, input logic [1:0] p, output int t);
      @(negedge clk);
      chk("req_ready_before_issue", bus.req_ready, 1'b1);
      bus.req_valid   = 1'b1;
      bus.req_nt_addr = a;
      bus.req_pal     = p;
      t = cyc + 1;
   endtask

   task automatic release_req();
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready && sb.size() == 0) ok = 1'b1;
      end
      if (!ok) chk("idle_timeout", sb.size(), 0);
   endtask

   initial begin
      int t;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 16'h0000);
      chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
      rst_n = 1'b1;

      // Quadrant 0, zero-wait
      rd_data = 8'h00; ack_wait = 0;
      issue(16'h2000, 2'd3, t); exp_rw(16'h23C0, 8'h03, 8'h00, t, 0); release_req();
      wait_idle();

      // Quadrant 3; request inputs change after transfer and must be ignored
      rd_data = 8'hFF;
      issue(16'h2462, 2'd1, t); exp_rw(16'h27C0, 8'h7F, 8'hFF, t, 0); release_req();
      bus.req_nt_addr = 16'h2000; bus.req_pal = 2'd3;
      wait_idle();

      // Quadrant 1, three wait cycles per access, inputs held
      rd_data = 8'hAA; ack_wait = 3;
      issue(16'h2BBF, 2'd0, t); exp_rw(16'h2BFF, 8'hA2, 8'hAA, t, 3); release_req();
      wait_idle();

      // Quadrant 2
      rd_data = 8'h00; ack_wait = 0;
      issue(16'h2040, 2'd2, t); exp_rw(16'h23C0, 8'h20, 8'h00, t, 0); release_req();
      wait_idle();

      // Address inside the attribute table: no access, done+err next cycle
      issue(16'h23C5, 2'd1, t); push_done(1'b1, t + 1); release_req();
      wait_idle();

      // Timeout in RD after 16 wait cycles
      no_ack = 1'b1;
      issue(16'h2000, 2'd1, t); push_acc(1'b0, 16'h23C0, 8'h00, 0, 1'b1); push_done(1'b1, t + 17); release_req();
      wait_idle();
      chk("busy_after_timeout", bus.busy, 1'b0);
      no_ack = 1'b0;

      // Ack while idle must do nothing
      spurious = 1'b1;
      repeat (4) @(negedge clk);
      chk("busy_spurious_ack", bus.busy, 1'b0);
      spurious = 1'b0;
      @(negedge clk);

      // Reset while the write is outstanding
      rd_data = 8'h55; no_ack_wr = 1'b1;
      issue(16'h2000, 2'd2, t);
      push_acc(1'b0, 16'h23C0, 8'h00, t + 1, 1'b0);
      push_acc(1'b1, 16'h23C0, 8'h56, 0, 1'b1);
      release_req();
      @(negedge clk);
      chk("wr_before_reset", {bus.mem_req, bus.mem_we}, 2'b11);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_abort_mem_req", bus.mem_req, 1'b0);
      chk("rst_abort_req_ready", bus.req_ready, 1'b1);
      chk("rst_abort_done", bus.done, 1'b0);
      rst_n = 1'b1;
      sb.delete();
      no_ack_wr = 1'b0;
      repeat (4) @(negedge clk);

      // Normal operation after the abort
      rd_data = 8'hFF;
      issue(16'h2C21, 2'd2, t); exp_rw(16'h2FC0, 8'hFE, 8'hFF, t, 0); release_req();
      wait_idle();

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      nerr++;
      $display("FAIL watchdog: simulation did not complete, expected end before time 200000");
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/attr_writer.md
ATTR_WRITER -- requirements
Module: attr_writer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles to wait for mem_ack before abort.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 req_valid  in  1  write-palette request.
REQ-005 req_ready  out  1  high in IDLE only; transfer when req_valid && req_ready.
REQ-006 req_nt_addr  in  16  nametable tile address (0x2000-0x2FFF).
REQ-007 req_pal  in  2  palette select to store for that tile.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  one-cycle pulse coincident with done on failure.
REQ-011 mem_req  out  1  VRAM access request.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-013 mem_addr  out  16  VRAM byte address.
REQ-014 mem_wdata  out  8  write data.
REQ-015 mem_rdata  in  8  read data, valid when mem_ack.
REQ-016 mem_ack  in  1  access complete; may assert in the first mem_req cycle.

Function
REQ-017 SHALL latch req_nt_addr and req_pal on transfer; later input changes are ignored until IDLE.
REQ-018 Address map: base = addr & 0xFC00, off = addr & 0x03FF, row = off[9:5], col = off[4:0].
REQ-019 Attribute address = base + 0x3C0 + (row>>2)*8 + (col>>2), 16-bit, no carry out of base.
REQ-020 Quadrant k = {row[1], col[1]}; req_pal replaces byte bits [2k+1:2k], all other bits preserved.
REQ-021 FSM states: IDLE, RD, WR, VFY (macro only), FIN.
REQ-022 IDLE -> RD on transfer; RD: mem_req=1, mem_we=0; on mem_ack capture mem_rdata, -> WR.
REQ-023 WR: mem_req=1, mem_we=1, mem_wdata = modified byte; on mem_ack -> FIN (or VFY).
REQ-024 mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable from assertion until the mem_ack cycle; mem_req SHALL be low the cycle after the ack.
REQ-025 FIN: done=1 for one cycle, -> IDLE; minimum latency: transfer at T, read at T+1, write at T+2, done at T+3.
REQ-026 If off >= 0x3C0 (the address is itself in the attribute area), no memory access; -> FIN with err=1.
REQ-027 Wait counter resets on each state entry; reaching TIMEOUT_CYCLES without mem_ack -> FIN with err=1, mem_req dropped.
REQ-028 mem_ack outside RD/WR/VFY SHALL be ignored.

Reset
REQ-029 With rst_n low at a clock edge: state IDLE, counter 0; next cycle req_ready=1 and busy=done=err=mem_req=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-access SHALL abort the access immediately with no done pulse.

Configuration
REQ-031 Macro ATTR_WRITER_READBACK_EN: when defined, WR -> VFY re-reads the attribute address and compares; mismatch -> err=1 in FIN.
REQ-032 When undefined, VFY does not exist and WR -> FIN directly; latency per REQ-025.

Structure
REQ-033 Shared package ppu_attr_pkg: constants ATTR_TABLE_OFS=16'h03C0, NT_BASE_MASK=16'hFC00, NT_OFS_MASK=16'h03FF, and the state encoding.
REQ-034 One combinational sub-module, attr_addr_calc (address -> attribute address, k, out-of-range flag); the FSM, counter and byte merge stay in attr_writer.

Verification
REQ-035 Addr 0x2000, pal 3, rdata 0x00, zero-wait ack -> read 0x23C0, write 0x23C0 data 0x03, done at T+3, err=0.
REQ-036 Addr 0x2462, pal 1, rdata 0xFF -> read and write 0x27C0, wdata 0x7F (k=3).
REQ-037 Addr 0x2BBF, pal 0, rdata 0xAA, ack after 3-cycle wait -> address 0x2BFF, wdata 0xA2 (k=1); request inputs held stable during the wait.
REQ-038 Addr 0x23C5 -> no mem_req, done+err one cycle after transfer.
REQ-039 TIMEOUT_CYCLES=16, no ack in RD -> done+err after 16 wait cycles, then req_ready=1.
REQ-040 rst_n low during WR with mem_req high -> next cycle mem_req=0, req_ready=1, no done; with the macro defined, a readback of 0x00 versus written 0x03 -> err=1.
